// File: rtl/mem_wb_pkg.sv
// Shared types and limits for the banked Wishbone SRAM controller.
package mem_wb_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    localparam int MAX_BANKS  = 8;
    localparam int MAX_RD_LAT = 3;
    localparam int WB_DW      = 32;
    localparam int WB_SELW    = 4;
    localparam int SRAM_AW    = 9;
endpackage

// File: rtl/mem_bank.sv
// One SRAM bank. Extra output registers give every bank the same
// RD_LAT edges from address capture to valid data.
module mem_bank
    import mem_wb_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int ROW_W  = 9
) (
    input  logic               clk_i,
    input  logic               csb_i,
    input  logic               web_i,
    input  logic [WB_SELW-1:0] wmask_i,
    input  logic [ROW_W-1:0]   row_i,
    input  logic [WB_DW-1:0]   din_i,
    output logic [WB_DW-1:0]   dout_o
);
    logic [WB_DW-1:0] sram_dout;
    logic [WB_DW-1:0] unused_dout1;

    sky130_sram_2kbyte_1rw1r_32x512_8 u_sram (
        .clk0   (clk_i),
        .csb0   (csb_i),
        .web0   (web_i),
        .wmask0 (wmask_i),
        .addr0  (SRAM_AW'(row_i)),
        .din0   (din_i),
        .dout0  (sram_dout),
        .clk1   (clk_i),
        .csb1   (1'b1),
        .addr1  ('0),
        .dout1  (unused_dout1)
    );

    if (RD_LAT > 1) begin : g_pipe
        logic [RD_LAT-2:0][WB_DW-1:0] pipe_q;
        always_ff @(posedge clk_i) begin
            pipe_q[0] <= sram_dout;
            for (int i = 1; i < RD_LAT - 1; i++) pipe_q[i] <= pipe_q[i-1];
        end
        assign dout_o = pipe_q[RD_LAT-2];
    end else begin : g_nopipe
        assign dout_o = sram_dout;
    end
endmodule

// File: rtl/sky130_sram_2kbyte_1rw1r_32x512_8.sv
// Behavioural stand-in for the 512x32 1rw1r SRAM macro.
// Port 0 is read/write, port 1 is read-only. Enables are active low.
module sky130_sram_2kbyte_1rw1r_32x512_8 (
    input  logic        clk0,
    input  logic        csb0,
    input  logic        web0,
    input  logic [3:0]  wmask0,
    input  logic [8:0]  addr0,
    input  logic [31:0] din0,
    output logic [31:0] dout0,
    input  logic        clk1,
    input  logic        csb1,
    input  logic [8:0]  addr1,
    output logic [31:0] dout1
);
    logic [31:0] mem [512];

    always_ff @(posedge clk0) begin
        if (!csb0) begin
            if (!web0) begin
                for (int b = 0; b < 4; b++) begin
                    if (wmask0[b]) mem[addr0][8*b +: 8] <= din0[8*b +: 8];
                end
            end else begin
                dout0 <= mem[addr0];
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (!csb1) dout1 <= mem[addr1];
    end
endmodule

// File: rtl/mem_wb_banked.sv
// Wishbone slave over NUM_BANKS SRAM banks: accept/ack FSM, registered
// bank steering for read data, error termination for out-of-range words.
module mem_wb_banked
    import mem_wb_pkg::*;
#(
    parameter int NUM_BANKS  = 2,
    parameter int BANK_WORDS = 512,
    parameter int RD_LAT     = 1,
    parameter int ADR_W      = $clog2(NUM_BANKS * BANK_WORDS)
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [31:0]        wb_adr_i,
    input  logic [WB_DW-1:0]   wb_dat_i,
    input  logic [WB_SELW-1:0] wb_sel_i,
    input  logic               wb_we_i,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    output logic               wb_ack_o,
    output logic               wb_err_o,
    output logic [WB_DW-1:0]   wb_dat_o
);
    localparam int ROW_W  = $clog2(BANK_WORDS);
    localparam int BSEL_W = $clog2(MAX_BANKS);
    localparam int CNT_W  = $clog2(MAX_RD_LAT);
    localparam logic [ADR_W:0] TOTAL_WORDS = (ADR_W+1)'(NUM_BANKS * BANK_WORDS);

    logic [ADR_W-1:0]  idx;
    logic [ADR_W:0]    idx_x;
    logic [BSEL_W-1:0] bank;
    logic [ROW_W-1:0]  row;
    logic              in_range;
    logic              req;
    logic              unused_adr;

    assign idx        = wb_adr_i[ADR_W+1:2];
    assign idx_x      = {1'b0, idx};
    assign bank       = BSEL_W'(idx_x >> ROW_W);
    assign row        = idx[ROW_W-1:0];
    assign in_range   = idx_x < TOTAL_WORDS;
    assign unused_adr = ^{wb_adr_i[1:0], wb_adr_i[31:ADR_W+2]};

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BSEL_W-1:0] bsel_q, bsel_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              rd_q, rd_d;

    assign req = wb_cyc_i & wb_stb_i & (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bsel_d  = bsel_q;
        rd_d    = rd_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    bsel_d = bank;
                    rd_d   = !wb_we_i && in_range;
                    if (!in_range) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else if (wb_we_i || RD_LAT == 1) begin
                        ack_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d   = CNT_W'(RD_LAT - 1);
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                // cyc drop abandons the read; the SRAM result is simply never steered out
                if (!wb_cyc_i) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    cnt_d   = '0;
                    ack_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bsel_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bsel_q  <= bsel_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
        end
    end

    // Enables are not gated by reset: a write launched in a reset cycle still lands.
    logic [NUM_BANKS-1:0] bank_csb;
    always_comb begin
        bank_csb = '1;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (req && in_range && bank == BSEL_W'(b)) bank_csb[b] = 1'b0;
        end
    end

    logic [NUM_BANKS-1:0][WB_DW-1:0] bank_dout;
    logic [MAX_BANKS-1:0][WB_DW-1:0] dout_pad;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        mem_bank #(.RD_LAT(RD_LAT), .ROW_W(ROW_W)) u_bank (
            .clk_i   (wb_clk_i),
            .csb_i   (bank_csb[b]),
            .web_i   (!wb_we_i),
            .wmask_i (wb_sel_i),
            .row_i   (row),
            .din_i   (wb_dat_i),
            .dout_o  (bank_dout[b])
        );
    end

    always_comb begin
        dout_pad = '0;
        for (int b = 0; b < NUM_BANKS; b++) dout_pad[b] = bank_dout[b];
    end

    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_dat_o = (ack_q && rd_q) ? dout_pad[bsel_q] : '0;
endmodule

// File: doc/mem_wb_banked.md
Name: mem_wb_banked

Overview:
- Parametrised Wishbone-slave SRAM controller; successor to the fixed two-bank 4 KB user memory.
- Generalises bank count, bank depth and SRAM read latency.
- Adds an explicit accept/ack FSM with registered bank steering, per-access SRAM enables, abort on cyc drop, and wb_err_o for out-of-range addresses.
- Sits on the user-project Wishbone bus behind the external address decoder.

Parameters:
- NUM_BANKS, 2, number of SRAM banks (1..8, need not be a power of two)
- BANK_WORDS, 512, 32-bit words per bank (power of two)
- RD_LAT, 1, SRAM clock edges from address capture to valid dout (1..3)
- ADR_W, $clog2(NUM_BANKS*BANK_WORDS), derived word-address width; not overridden

Ports:
- wb_clk_i  in  1  sole clock; all state on rising edge
- wb_rst_i  in  1  reset, synchronous, active-high
- wb_adr_i  in  32  byte address; [1:0] ignored; word index = wb_adr_i[ADR_W+1:2]
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte lane enables (writes only)
- wb_we_i  in  1  1 = write
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_ack_o  out  1  normal termination, one-cycle pulse
- wb_err_o  out  1  error termination, one-cycle pulse
- wb_dat_o  out  32  read data, valid only while wb_ack_o=1 on a read, else 0

Behaviour:
- Reset (synchronous, active-high on wb_clk_i): FSM to IDLE; wb_ack_o=0, wb_err_o=0, wb_dat_o=0, latency counter=0, bank-select register=0. SRAM contents untouched.
- Accept: in IDLE, cyc & stb sampled at edge T0 = accepted request. No request is accepted while BUSY or in the cycle wb_ack_o/wb_err_o is high.
- Decode at accept: index = wb_adr_i[ADR_W+1:2]; bank = index / BANK_WORDS; row = index % BANK_WORDS.
- Out-of-range (index >= NUM_BANKS*BANK_WORDS): no SRAM enable; wb_err_o=1 for the cycle after T0, wb_ack_o stays 0; FSM -> RESP -> IDLE.
- Write: only the selected bank gets csb active for the single T0 cycle; wmask = wb_sel_i.
  - sel=0000 is still acked, with no byte modified.
  - wb_ack_o=1 for the cycle after T0.
- Read: selected bank enabled for the T0 cycle only; bank index registered at T0 and used to steer the dout mux.
  - wb_ack_o=1 in the cycle after edge T0+RD_LAT-1, i.e. ack latency RD_LAT cycles.
  - wb_dat_o carries that bank's word in the same cycle.
  - FSM IDLE -> BUSY (counter loads RD_LAT-1, skipped if 0) -> RESP -> IDLE.
- Throughput: writes one per 2 cycles; reads one per RD_LAT+1 cycles.
- Abort: wb_cyc_i low while BUSY -> IDLE next edge, no ack; SRAM read result discarded. An accepted write has already been committed.
- Address or data changing after T0 has no effect on the access in flight, since the bank select is registered.
- Reset asserted mid-read -> IDLE, no ack; any write enabled in that same cycle is still performed by the SRAM.
- Unused banks (index gap) are never enabled.

Decomposition:
- Shared package mem_wb_pkg: FSM state enum (IDLE, BUSY, RESP), MAX_BANKS=8, MAX_RD_LAT=3, WB_DW=32, WB_SELW=4.
- One sub-module, mem_bank: wraps one sky130_sram_2kbyte_1rw1r_32x512_8 instance (port 1 tied off).
  - Adds RD_LAT-1 output pipeline registers so every bank presents a uniform latency.
  - Instantiated NUM_BANKS times in a generate loop.
- Top holds FSM, decode, err logic and output mux.

Test Plan:
- Reset then idle 5 cycles -> ack, err, dat_o all 0; SRAM csb inactive every cycle.
- RD_LAT=1, NUM_BANKS=2: write 0xDEADBEEF sel=1111 to 0x000, then 0xCAFEF00D to 0x800 (bank 1, row 0); read both.
  - -> write acks exactly 1 cycle after accept.
  - -> reads ack 1 cycle after accept with correct words, proving bank steering.
- Byte lanes: write 0x11223344 to 0x004, then write 0xAABBCCDD sel=0101, read -> 0x11BB33DD.
- NUM_BANKS=3, RD_LAT=2: read 0x1800 (index 1536) -> wb_err_o pulse 1 cycle after accept, no ack, no bank enabled. Read 0x17FC -> ack 2 cycles after accept.
- Back-to-back reads with stb held high continuously -> exactly one ack per RD_LAT+1 cycles, none double-accepted in an ack cycle.
  - Change wb_adr_i to another bank the cycle after accept -> data still from the original bank.
- RD_LAT=3: drop cyc 1 cycle after a read accept -> no ack. Assert wb_rst_i mid-read -> no ack, outputs 0 next cycle, and a subsequent read returns prior contents.
